// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register.
//  - default width constants for the stage payload
//  - bit positions of the control fields inside the ctrl vector
//  - packed control struct (MSB first, matches the bit positions below)
//  - slot-occupancy state encoding used by the stage FSM
package pipe_pkg;

  localparam int unsigned DefCtrlW  = 9;
  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefNumData = 4;
  localparam int unsigned DefRegW   = 5;
  localparam int unsigned DefNumReg = 3;

  localparam int unsigned CTRL_ALU_OP_LSB = 0;
  localparam int unsigned CTRL_ALU_OP_W   = 3;
  localparam int unsigned CTRL_REG_DST    = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_MEM_READ   = 5;
  localparam int unsigned CTRL_MEM_WRITE  = 6;
  localparam int unsigned CTRL_REG_WRITE  = 7;
  localparam int unsigned CTRL_MEM_TO_REG = 8;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_op;
  } ctrl_t;

  // Which slots hold a live entry: none, main only, main plus skid.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } slot_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline register: a valid bit, a control field and a payload.
//  clk_i    clock, rising edge
//  rst_ni   asynchronous reset, active-low; clears valid, ctrl and payload
//  flush_i  clear valid and zero the stored ctrl (payload kept)
//  load_i   capture ctrl_i/pay_i and set valid
//  drop_i   clear valid only (entry issued, nothing replaces it)
//  ctrl_i   control bits to capture
//  pay_i    payload to capture
//  valid_o  slot holds a live entry
//  ctrl_o   stored control bits
//  pay_o    stored payload
module pipe_slot #(
  parameter int unsigned CtrlW = 9,
  parameter int unsigned PayW  = 143
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             drop_i,
  input  logic [CtrlW-1:0] ctrl_i,
  input  logic [PayW-1:0]  pay_i,
  output logic             valid_o,
  output logic [CtrlW-1:0] ctrl_o,
  output logic [PayW-1:0]  pay_o
);

  logic             valid_d, valid_q;
  logic [CtrlW-1:0] ctrl_d, ctrl_q;
  logic [PayW-1:0]  pay_d, pay_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pay_d   = pay_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      pay_d   = pay_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pay_q   <= pay_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign pay_o   = pay_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, flush and an
// optional one-entry skid slot.
//  clk, rst (async, active-low), flush (synchronous, drops all entries)
//  in_valid/in_ready/in_ctrl/in_data/in_regs       upstream side
//  out_valid/out_ready/out_ctrl/out_data/out_regs  downstream side
// With SKID=1 in_ready comes straight from the skid valid flop; with SKID=0 it is
// combinational from out_valid/out_ready. out_ctrl is zero whenever out_valid is low.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W   = DefCtrlW,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NUM_DATA = DefNumData,
  parameter int unsigned REG_W    = DefRegW,
  parameter int unsigned NUM_REG  = DefNumReg,
  parameter int unsigned SKID     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [NUM_REG*REG_W-1:0]   in_regs,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [NUM_REG*REG_W-1:0]   out_regs
);

  localparam int unsigned DataBits = NUM_DATA * DATA_W;
  localparam int unsigned RegBits  = NUM_REG * REG_W;
  localparam int unsigned PayW     = DataBits + RegBits;
  localparam bit          Skid     = (SKID != 0);

  logic [PayW-1:0]   in_pay, main_pay, skid_pay, main_pay_src;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_src;
  logic              main_valid, skid_valid;
  logic              accept, issue;
  logic              main_load, main_drop, skid_load, skid_drop, from_skid;

  slot_state_e state_d, state_q;

  assign in_pay = {in_regs, in_data};
  assign accept = in_valid & in_ready;
  assign issue  = main_valid & out_ready;

  // Slot-select: decides which slot loads/drops this edge. A skid entry always moves into
  // main before any new input, which keeps ordering intact.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_drop = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    from_skid = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = StOne;
          end
        end
        StOne: begin
          if (issue) begin
            if (accept) begin
              main_load = 1'b1;
            end else begin
              main_drop = 1'b1;
              state_d   = StEmpty;
            end
          end else if (accept && Skid) begin
            skid_load = 1'b1;
            state_d   = StTwo;
          end
        end
        StTwo: begin
          if (issue) begin
            main_load = 1'b1;
            from_skid = 1'b1;
            skid_drop = 1'b1;
            state_d   = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_ctrl_src = from_skid ? skid_ctrl : in_ctrl;
  assign main_pay_src  = from_skid ? skid_pay : in_pay;

  pipe_slot #(
    .CtrlW (CTRL_W),
    .PayW  (PayW)
  ) u_main (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (flush),
    .load_i  (main_load),
    .drop_i  (main_drop),
    .ctrl_i  (main_ctrl_src),
    .pay_i   (main_pay_src),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .pay_o   (main_pay)
  );

  if (Skid) begin : g_skid
    pipe_slot #(
      .CtrlW (CTRL_W),
      .PayW  (PayW)
    ) u_skid (
      .clk_i   (clk),
      .rst_ni  (rst),
      .flush_i (flush),
      .load_i  (skid_load),
      .drop_i  (skid_drop),
      .ctrl_i  (in_ctrl),
      .pay_i   (in_pay),
      .valid_o (skid_valid),
      .ctrl_o  (skid_ctrl),
      .pay_o   (skid_pay)
    );
    assign in_ready = ~skid_valid;
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_pay   = '0;
    assign in_ready   = ~main_valid | out_ready;
  end

  assign out_valid = main_valid;
  // Gate as well as clear-on-flush: a bubble must never carry a write enable downstream.
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_pay[DataBits-1:0];
  assign out_regs  = main_pay[DataBits +: RegBits];

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  typedef struct packed {
    logic [8:0]   ctrl;
    logic [127:0] data;
    logic [14:0]  regs;
  } ent_t;

  logic         clk, rst, flush, in_valid, out_ready;
  logic [8:0]   in_ctrl;
  logic [127:0] in_data;
  logic [14:0]  in_regs;

  logic         in_ready1, out_valid1, in_ready0, out_valid0;
  logic [8:0]   out_ctrl1, out_ctrl0;
  logic [127:0] out_data1, out_data0;
  logic [14:0]  out_regs1, out_regs0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  ent_t q1[$];
  ent_t q0[$];
  ent_t last1, last0;
  ctrl_t cs;

  pipe_stage_reg #(.SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_regs(in_regs), .out_valid(out_valid1),
    .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1), .out_regs(out_regs1)
  );

  pipe_stage_reg #(.SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_regs(in_regs), .out_valid(out_valid0),
    .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0), .out_regs(out_regs0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input int n, input logic [8:0] c);
    ent_t e;
    e.ctrl = c;
    e.data = {32'(n + 3000), 32'(n + 2000), 32'(n + 1000), 32'(n)};
    e.regs = {5'(n + 2), 5'(n + 1), 5'(n)};
    return e;
  endfunction

  task automatic drive(input bit v, input int n, input logic [8:0] c);
    ent_t e;
    e = mk(n, c);
    in_valid = v;
    in_ctrl  = e.ctrl;
    in_data  = e.data;
    in_regs  = e.regs;
  endtask

  // Reference model: a FIFO of capacity 2 (skid) or 1 (no skid). Head is what is shown
  // downstream; the last head seen is what out_data/out_regs keep showing in a bubble.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q1.delete();
        q0.delete();
        last1 = '0;
        last0 = '0;
      end else begin
        bit   acc1, acc0, iss1, iss0;
        ent_t e;
        e    = '{ctrl: in_ctrl, data: in_data, regs: in_regs};
        acc1 = in_valid && (q1.size() < 2);
        iss1 = out_ready && (q1.size() > 0);
        acc0 = in_valid && ((q0.size() == 0) || out_ready);
        iss0 = out_ready && (q0.size() > 0);
        if (flush) begin
          q1.delete();
          q0.delete();
        end else begin
          if (iss1) void'(q1.pop_front());
          if (acc1) q1.push_back(e);
          if (iss0) void'(q0.pop_front());
          if (acc0) q0.push_back(e);
        end
        if (q1.size() > 0) last1 = q1[0];
        if (q0.size() > 0) last0 = q0[0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m1_out_valid", out_valid1, q1.size() > 0);
      check("m1_out_ctrl", out_ctrl1, (q1.size() > 0) ? q1[0].ctrl : 9'h000);
      check("m1_out_data", out_data1, last1.data);
      check("m1_out_regs", out_regs1, last1.regs);
      check("m1_in_ready", in_ready1, q1.size() < 2);
      check("m0_out_valid", out_valid0, q0.size() > 0);
      check("m0_out_ctrl", out_ctrl0, (q0.size() > 0) ? q0[0].ctrl : 9'h000);
      check("m0_out_data", out_data0, last0.data);
      check("m0_out_regs", out_regs0, last0.regs);
      check("m0_in_ready", in_ready0, (q0.size() == 0) || out_ready);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 9'h000);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset_valid", out_valid1, 1'b0);
    check("reset_data", out_data1, 128'h0);
    check("reset_ready", in_ready1, 1'b1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    step();

    // Streaming 1..8 back to back
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1, k, 9'(k));
      step();
      check("stream_data1", out_data1[31:0], 32'(k));
      check("stream_data0", out_data0[31:0], 32'(k));
      check("stream_ready1", in_ready1, 1'b1);
    end
    drive(0, 0, 9'h000);
    step();

    // Backpressure: A held, B in skid, C waits upstream
    out_ready = 1'b0;
    drive(1, 'hA, 9'h0AA);
    step();
    drive(1, 'hB, 9'h0BB);
    step();
    check("bp_hold_a", out_data1[31:0], 32'hA);
    check("bp_ready_low", in_ready1, 1'b0);
    drive(1, 'hC, 9'h0CC);
    step();
    check("bp_still_a", out_data1[31:0], 32'hA);
    check("bp_still_low", in_ready1, 1'b0);
    out_ready = 1'b1;
    step();
    check("bp_out_b", out_data1[31:0], 32'hB);
    check("bp_out_b_ctrl", out_ctrl1, 9'h0BB);
    step();
    check("bp_out_c", out_data1[31:0], 32'hC);
    drive(0, 0, 9'h000);

    // Flush with both slots full and D offered
    out_ready = 1'b0;
    drive(1, 'hE, 9'h0EE);
    step();
    check("fl_full", in_ready1, 1'b0);
    drive(1, 'hD, 9'h1DD);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 0, 9'h000);
    check("fl_valid", out_valid1, 1'b0);
    check("fl_ctrl", out_ctrl1, 9'h000);
    check("fl_ready", in_ready1, 1'b1);
    out_ready = 1'b1;
    // Flush while both stages are ready to accept: the offered entry must vanish
    drive(1, 'hF, 9'h1FF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 0, 9'h000);
    check("fl_drop1", out_valid1, 1'b0);
    check("fl_drop0", out_valid0, 1'b0);
    repeat (2) step();

    // Asynchronous reset with both skid slots full
    out_ready = 1'b0;
    drive(1, 'h11, 9'h1FF);
    step();
    drive(1, 'h12, 9'h1FF);
    step();
    drive(0, 0, 9'h000);
    #2 rst = 1'b0;
    #1;
    check("ar_valid", out_valid1, 1'b0);
    check("ar_ctrl", out_ctrl1, 9'h000);
    check("ar_data", out_data1, 128'h0);
    check("ar_regs", out_regs1, 15'h0);
    step();
    rst = 1'b1;
    #1;
    check("ar_ready1", in_ready1, 1'b1);
    check("ar_ready0", in_ready0, 1'b1);
    step();

    // SKID=0: combinational in_ready and 1-cycle latency of ctrl 1FF
    drive(1, 'h55, 9'h1FF);
    #1;
    check("s0_ready_empty", in_ready0, 1'b1);
    step();
    drive(0, 0, 9'h000);
    check("s0_ctrl", out_ctrl0, 9'h1FF);
    check("s0_ready_held", in_ready0, 1'b0);
    out_ready = 1'b1;
    #1;
    check("s0_ready_rise", in_ready0, 1'b1);
    out_ready = 1'b0;
    #1;
    check("s0_ready_fall", in_ready0, 1'b0);
    out_ready = 1'b1;
    step();

    // Bubble: ctrl offered without valid must not leak
    drive(0, 'h66, 9'h1FF);
    step();
    check("bub_valid1", out_valid1, 1'b0);
    check("bub_ctrl1", out_ctrl1, 9'h000);
    cs = ctrl_t'(out_ctrl0);
    check("bub_regwr0", cs.reg_write, 1'b0);
    check("bub_memwr0", cs.mem_write, 1'b0);

    // Mixed traffic against the model
    for (int i = 0; i < 48; i++) begin
      drive((i % 3) != 2, 'h100 + i, 9'(i * 37));
      out_ready = ((i % 5) != 1) && ((i % 7) != 3);
      flush = (i == 30);
      step();
    end
    flush = 1'b0;
    drive(0, 0, 9'h000);
    out_ready = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
